// File: rtl/multi_sum_pkg.sv
// rtl/multi_sum_pkg.sv - shared sizing helpers for the multi-operand FIFO adder
package multi_sum_pkg;

  localparam int SUM_COUNT_W = 16;

  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/arst_n_valid_ready_fifo.sv
// rtl/arst_n_valid_ready_fifo.sv - valid/ready FIFO, any depth, async active-low reset
module arst_n_valid_ready_fifo
  import multi_sum_pkg::*;
#(
  parameter int width = 8,
  parameter int depth = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [width-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [width-1:0] out_data
);

  localparam int PW = ptr_w(depth);
  localparam int CW = cnt_w(depth);
  localparam logic [PW-1:0] LAST = PW'(depth - 1);
  localparam logic [CW-1:0] FULL = CW'(depth);

  logic [width-1:0] mem [depth];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             push;
  logic             pop;

  // Ready is held low while reset is asserted; a full FIFO never passes through.
  assign in_ready  = rst & (count != FULL);
  assign out_valid = (count != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign out_data  = out_valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + PW'(1);
      if (pop)  rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + PW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

endmodule

// File: rtl/multi_operand_sum_using_fifos.sv
// rtl/multi_operand_sum_using_fifos.sv - N-channel FIFO-buffered streaming adder (option: MULTI_SUM_PIPE_EN)
module multi_operand_sum_using_fifos
  import multi_sum_pkg::*;
#(
  parameter int width     = 8,
  parameter int n_inputs  = 4,
  parameter int depth     = 10,
  parameter int out_width = width + $clog2(n_inputs)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [n_inputs-1:0]       in_valid,
  output logic [n_inputs-1:0]       in_ready,
  input  logic [n_inputs*width-1:0] in_data,
  output logic                      sum_valid,
  input  logic                      sum_ready,
  output logic [out_width-1:0]      sum_data,
  output logic [SUM_COUNT_W-1:0]    sum_count
);

  logic [n_inputs-1:0] ch_valid;
  logic [width-1:0]    ch_data [n_inputs];
  logic                all_valid;
  logic                join_ready;
  logic                join_fire;
  logic [out_width-1:0] sum_comb;
  logic                res_valid;
  logic                res_ready;
  logic [out_width-1:0] res_data;

  for (genvar i = 0; i < n_inputs; i++) begin : g_ch
    arst_n_valid_ready_fifo #(.width(width), .depth(depth)) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid[i]),
      .in_ready  (in_ready[i]),
      .in_data   (in_data[i*width +: width]),
      .out_valid (ch_valid[i]),
      .out_ready (join_fire),
      .out_data  (ch_data[i])
    );
  end

  // All channels pop together or not at all.
  assign all_valid = &ch_valid;
  assign join_fire = all_valid & join_ready;

  always_comb begin
    sum_comb = '0;
    for (int i = 0; i < n_inputs; i++) sum_comb = sum_comb + out_width'(ch_data[i]);
  end

`ifdef MULTI_SUM_PIPE_EN
  logic                 pipe_valid;
  logic [out_width-1:0] pipe_data;

  // Stage reloads whenever it is empty or draining, so throughput stays at one per cycle.
  assign join_ready = ~pipe_valid | res_ready;
  assign res_valid  = pipe_valid;
  assign res_data   = pipe_data;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pipe_valid <= 1'b0;
      pipe_data  <= '0;
    end else if (join_ready) begin
      pipe_valid <= all_valid;
      pipe_data  <= sum_comb;
    end
  end
`else
  assign join_ready = res_ready;
  assign res_valid  = all_valid;
  assign res_data   = sum_comb;
`endif

  arst_n_valid_ready_fifo #(.width(out_width), .depth(depth)) u_res_fifo (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (res_valid),
    .in_ready  (res_ready),
    .in_data   (res_data),
    .out_valid (sum_valid),
    .out_ready (sum_ready),
    .out_data  (sum_data)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                        sum_count <= '0;
    else if (sum_valid && sum_ready) sum_count <= sum_count + SUM_COUNT_W'(1);
  end

endmodule

// File: tb/tb_multi_operand_sum_using_fifos.sv
// tb/tb_multi_operand_sum_using_fifos.sv - randomized self-checking bench against a queue model
module tb_multi_operand_sum_using_fifos;

  localparam int W = 8;
  localparam int N = 4;
  localparam int D = 10;
  localparam int OW = 10;
  localparam int HIST = 4096;
`ifdef MULTI_SUM_PIPE_EN
  localparam int EXTRA = 1;
`else
  localparam int EXTRA = 0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  in_valid;
  logic [N-1:0]  in_ready;
  logic [N*W-1:0] in_data;
  logic          sum_valid;
  logic          sum_ready;
  logic [OW-1:0] sum_data;
  logic [15:0]   sum_count;
  logic [N-1:0]  in_ready8;
  logic          sum_valid8;
  logic [7:0]    sum_data8;
  logic [15:0]   sum_count8;

  int n_checks = 0;
  int n_errors = 0;
  int hist [N][HIST];
  int wr_idx [N];
  int rd_idx [N];
  int push_cnt [N];

  multi_operand_sum_using_fifos #(.width(W), .n_inputs(N), .depth(D)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .sum_valid(sum_valid), .sum_ready(sum_ready), .sum_data(sum_data), .sum_count(sum_count)
  );

  multi_operand_sum_using_fifos #(.width(W), .n_inputs(N), .depth(D), .out_width(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready8), .in_data(in_data),
    .sum_valid(sum_valid8), .sum_ready(sum_ready), .sum_data(sum_data8), .sum_count(sum_count8)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    for (int i = 0; i < N; i++) begin
      rd_idx[i]   = wr_idx[i];
      push_cnt[i] = 0;
    end
  endtask

  function automatic int min_pushes();
    int m = push_cnt[0];
    for (int i = 1; i < N; i++) if (push_cnt[i] < m) m = push_cnt[i];
    return m;
  endfunction

  task automatic drain(input int target, input string tag);
    int cyc = 0;
    while (sum_count != 16'(target) && cyc < 300) begin
      step();
      cyc++;
    end
    check(tag, 32'(sum_count), 32'(target));
  endtask

  // Model: the k-th result is the sum of the k-th accepted operand of every channel.
  always @(negedge clk) begin : mon
    int  e;
    bit  ok;
    if (rst) begin
      if (sum_valid && sum_ready) begin
        ok = 1'b1;
        e  = 0;
        for (int i = 0; i < N; i++) if (rd_idx[i] == wr_idx[i]) ok = 1'b0;
        if (!ok) begin
          check("spurious_result", 32'(sum_data), 32'hFFFF_FFFF);
        end else begin
          for (int i = 0; i < N; i++) begin
            e += hist[i][rd_idx[i] % HIST];
            rd_idx[i]++;
          end
          check("sum_data", 32'(sum_data), 32'(e % (1 << OW)));
          check("sum_valid_w8", 32'(sum_valid8), 32'd1);
          check("sum_data_w8", 32'(sum_data8), 32'(e % 256));
        end
      end
      for (int i = 0; i < N; i++) begin
        if (in_valid[i] && in_ready[i]) begin
          hist[i][wr_idx[i] % HIST] = int'(in_data[i*W +: W]);
          wr_idx[i]++;
          push_cnt[i]++;
        end
      end
    end
  end

  initial begin
    int base;
    for (int i = 0; i < N; i++) begin
      wr_idx[i] = 0;
      rd_idx[i] = 0;
      push_cnt[i] = 0;
    end
    rst = 1'b0;
    in_valid = '0;
    in_data = '0;
    sum_ready = 1'b0;
    repeat (3) step();
    check("rst_in_ready", 32'(in_ready), 32'h0);
    check("rst_sum_valid", 32'(sum_valid), 32'h0);
    check("rst_sum_data", 32'(sum_data), 32'h0);
    check("rst_sum_count", 32'(sum_count), 32'h0);
    rst = 1'b1;
    step();
    check("in_ready_after_rst", 32'(in_ready), 32'hF);

    // Scenario 1: 1+2+3+4 through empty FIFOs.
    sum_ready = 1'b1;
    in_valid = 4'hF;
    in_data = {8'd4, 8'd3, 8'd2, 8'd1};
    step();
    in_valid = '0;
    check("s1_valid_t", 32'(sum_valid), 32'h0);
    step();
`ifdef MULTI_SUM_PIPE_EN
    check("s1_valid_t1_pipe", 32'(sum_valid), 32'h0);
    step();
`endif
    check("s1_valid", 32'(sum_valid), 32'h1);
    check("s1_data", 32'(sum_data), 32'd10);
    step();
    check("s1_count", 32'(sum_count), 32'd1);
    check("s1_valid_after_pop", 32'(sum_valid), 32'h0);

    // Scenario 2: channel 3 withheld, others fill; then channel 3 releases the join.
    for (int k = 0; k < D; k++) begin
      in_valid = 4'b0111;
      in_data = $urandom();
      step();
    end
    in_valid = '0;
    check("s2_ready_low", 32'(in_ready), 32'h8);
    check("s2_no_sum", 32'(sum_valid), 32'h0);
    for (int k = 0; k < D; k++) begin
      in_valid = 4'b1000;
      in_data = $urandom();
      step();
    end
    in_valid = '0;
    drain(1 + D, "s2_drain");

    // Scenario 3: result side blocked while every channel streams 0xFF.
    sum_ready = 1'b0;
    in_valid = 4'hF;
    in_data = 32'hFFFF_FFFF;
    base = push_cnt[0];
    repeat (2 * D + 5) step();
    in_valid = '0;
    check("s3_pushes", 32'(push_cnt[0] - base), 32'(2 * D + EXTRA));
    check("s3_in_ready", 32'(in_ready), 32'h0);
    check("s3_sum_valid", 32'(sum_valid), 32'h1);
    check("s3_sum_data", 32'(sum_data), 32'h3FC);
    check("s3_sum_data_w8", 32'(sum_data8), 32'hFC);
    check("s3_count_held", 32'(sum_count), 32'(1 + D));
    sum_ready = 1'b1;
    drain(1 + D + 2 * D + EXTRA, "s3_drain");

    // Scenario 4: random valids, data and backpressure.
    for (int k = 0; k < 400; k++) begin
      in_valid = N'($urandom());
      in_data = $urandom();
      sum_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    in_valid = '0;
    sum_ready = 1'b1;
    drain(min_pushes(), "s4_count");

    // Scenario 5: reset while FIFOs are half full.
    sum_ready = 1'b0;
    for (int k = 0; k < D / 2; k++) begin
      in_valid = 4'hF;
      in_data = $urandom();
      step();
    end
    in_valid = '0;
    check("s5_pre_valid", 32'(sum_valid), 32'h1);
    rst = 1'b0;
    model_clear();
    #1;
    check("s5_in_ready", 32'(in_ready), 32'h0);
    check("s5_sum_valid", 32'(sum_valid), 32'h0);
    check("s5_sum_data", 32'(sum_data), 32'h0);
    check("s5_sum_count", 32'(sum_count), 32'h0);
    check("s5_sum_valid_w8", 32'(sum_valid8), 32'h0);
    step();
    rst = 1'b1;
    sum_ready = 1'b1;
    repeat (5) step();
    check("s5_no_stale", 32'(sum_valid), 32'h0);
    check("s5_count_zero", 32'(sum_count), 32'h0);
    in_valid = 4'hF;
    in_data = {8'd8, 8'd7, 8'd6, 8'd5};
    step();
    in_valid = '0;
    drain(1, "s5_restart");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
